// File: rtl/mult_seq32.sv
// Iterative 32-bit signed multiplier: one radix-2 Booth step per cycle on a 33-bit add path.
// Delivers the low product word and a signed-overflow flag 32 cycles after the start edge.
module mult_seq32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_mult,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH:0]   p_hi;
    logic             q_m1;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] result_q;
    logic             exc_q;

    logic [1:0]       booth;
    logic [WIDTH:0]   addend;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   p_step;
    logic [WIDTH-1:0] q_step;
    logic             qm1_step;
    logic             last_step;
    logic             exc_step;

    // Booth step: 33-bit add/subtract of the sign-extended multiplicand, then arithmetic shift
    always_comb begin
        booth  = {q_reg[0], q_m1};
        addend = '0;
        cin    = 1'b0;
        case (booth)
            2'b01: addend = {m_reg[WIDTH-1], m_reg};
            2'b10: begin
                addend = ~{m_reg[WIDTH-1], m_reg};
                cin    = 1'b1;
            end
            default: addend = '0;
        endcase
        sum       = p_hi + addend + {{WIDTH{1'b0}}, cin};
        p_step    = {sum[WIDTH], sum[WIDTH:1]};
        q_step    = {sum[0], q_reg[WIDTH-1:1]};
        qm1_step  = q_reg[0];
        last_step = (state == RUN) && !ctrl_mult && (cnt == CNT_W'(WIDTH - 1));
        exc_step  = (p_step[WIDTH-1:0] != {WIDTH{q_step[WIDTH-1]}});
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        busy           = 1'b0;
        data_resultRDY = 1'b0;
        case (state)
            RUN:  busy = 1'b1;
            DONE: data_resultRDY = 1'b1;
            default: ;
        endcase
        if (ctrl_mult) begin
            state_nxt = RUN;
        end else begin
            case (state)
                RUN:     if (cnt == CNT_W'(WIDTH - 1)) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_reg    <= '0;
            q_reg    <= '0;
            p_hi     <= '0;
            q_m1     <= 1'b0;
            cnt      <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else if (ctrl_mult) begin
            m_reg <= data_operandA;
            q_reg <= data_operandB;
            p_hi  <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
        end else if (state == RUN) begin
            p_hi <= p_step;
            q_reg <= q_step;
            q_m1 <= qm1_step;
            cnt  <= cnt + 1'b1;
            if (last_step) begin
                result_q <= q_step;
                exc_q    <= exc_step;
            end
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;

endmodule

// File: tb/tb_mult_seq32.sv
// Directed and short randomized checks for mult_seq32: product, overflow flag, RDY/busy timing,
// restart, and asynchronous reset abort.
module tb_mult_seq32;

    logic        clock;
    logic        reset;
    logic        ctrl_mult;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;

    mult_seq32 #(.WIDTH(32), .CNT_W(6)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_mult      (ctrl_mult),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Start edge happens inside; operands are scrambled right after to show they are not re-sampled
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_mult     = 1'b1;
        @(posedge clock);
        #1;
        ctrl_mult     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Called right after the start edge; k counts cycles after that edge, RDY expected at k==32
    task automatic wait_result(input string tag, input logic [31:0] exp_res, input logic exp_exc,
                               input logic [31:0] hold_val);
        int   rdy_at   = -1;
        int   rdy_cnt  = 0;
        int   busy_cnt = 0;
        bit   held     = 1'b1;
        logic [31:0] res_at_rdy = '0;
        logic        exc_at_rdy = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (data_resultRDY) begin
                if (rdy_at < 0) begin
                    rdy_at     = k;
                    res_at_rdy = data_result;
                    exc_at_rdy = data_exception;
                end
                rdy_cnt++;
            end else if (rdy_at < 0 && data_result !== hold_val) begin
                held = 1'b0;
            end
            if (busy) busy_cnt++;
        end
        check({tag, ".rdy_at"},   64'(rdy_at),   64'd32);
        check({tag, ".rdy_cnt"},  64'(rdy_cnt),  64'd1);
        check({tag, ".busy_cnt"}, 64'(busy_cnt), 64'd32);
        check({tag, ".held"},     64'(held),     64'd1);
        check({tag, ".result"},   64'(res_at_rdy), 64'(exp_res));
        check({tag, ".exc"},      64'(exc_at_rdy), 64'(exp_exc));
        check({tag, ".result_hold"}, 64'(data_result), 64'(exp_res));
    endtask

    task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res, input logic exp_exc);
        logic [31:0] prev;
        prev = data_result;
        start_op(a, b);
        wait_result(tag, exp_res, exp_exc, prev);
    endtask

    initial begin
        logic [31:0] prev;
        logic [63:0] prod;
        logic [31:0] ra, rb;
        int          rdy_seen;

        reset         = 1'b1;
        ctrl_mult     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset.result", 64'(data_result),    64'd0);
        check("reset.exc",    64'(data_exception), 64'd0);
        check("reset.rdy",    64'(data_resultRDY), 64'd0);
        check("reset.busy",   64'(busy),           64'd0);
        reset = 1'b0;

        run_vec("basic",    32'd3,          32'd5,          32'h0000000F, 1'b0);
        run_vec("neg_pos",  32'hFFFFFFF9,   32'd6,          32'hFFFFFFD6, 1'b0);
        run_vec("neg_neg",  32'hFFFFFFF9,   32'hFFFFFFFA,   32'h0000002A, 1'b0);
        run_vec("ovf_max2", 32'h7FFFFFFF,   32'd2,          32'hFFFFFFFE, 1'b1);
        run_vec("ovf_minm1",32'h80000000,   32'hFFFFFFFF,   32'h80000000, 1'b1);
        run_vec("ovf_2p32", 32'h00010000,   32'h00010000,   32'h00000000, 1'b1);
        run_vec("min_one",  32'h80000000,   32'd1,          32'h80000000, 1'b0);
        run_vec("m1_m1",    32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001, 1'b0);
        run_vec("zero",     32'h0,          32'h12345678,   32'h00000000, 1'b0);
        run_vec("min_min",  32'h80000000,   32'h80000000,   32'h00000000, 1'b1);

        // Restart mid-operation: only the second operation produces RDY
        prev = data_result;
        start_op(32'd3, 32'd5);
        rdy_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (data_resultRDY) rdy_seen++;
        end
        check("restart.no_rdy_early", 64'(rdy_seen), 64'd0);
        start_op(32'd4, 32'd4);
        wait_result("restart", 32'h00000010, 1'b0, prev);

        // Asynchronous reset partway through an operation
        start_op(32'h7FFFFFFF, 32'd3);
        repeat (15) @(negedge clock);
        #1 reset = 1'b1;
        #1;
        check("areset.result", 64'(data_result),    64'd0);
        check("areset.exc",    64'(data_exception), 64'd0);
        check("areset.rdy",    64'(data_resultRDY), 64'd0);
        check("areset.busy",   64'(busy),           64'd0);
        #1 reset = 1'b0;
        rdy_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (data_resultRDY || busy) rdy_seen++;
        end
        check("areset.no_rdy", 64'(rdy_seen), 64'd0);
        run_vec("after_reset", 32'd2, 32'd2, 32'h00000004, 1'b0);

        // Short randomized sweep against a 64-bit reference product
        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 1) ra = ra >> ($urandom % 32);
            if (i % 4 == 2) rb = {{16{rb[15]}}, rb[15:0]};
            prod = {{32{ra[31]}}, ra} * {{32{rb[31]}}, rb};
            run_vec($sformatf("rand%0d", i), ra, rb, prod[31:0],
                    prod[63:32] != {32{prod[31]}});
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
